pll_lock_rst_ctrl: RTL and testbench



---
 rtl/pll_lock_rst_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pll_lock_rst_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_rst_ctrl.sv
// pll_lock_rst_ctrl
//
// PLL reset / lock sequencer running on the free-running board reference
// clock. Pulses the PLL reset, waits for lock with a per-attempt timeout and
// a bounded number of retries, requires lock to be continuously present for
// LOCK_STABLE_CYCLES before releasing the system reset of the PLL clock
// domains, and re-sequences (counting the event) whenever lock drops in RUN.
//
// Ports
//   clk           free-running reference clock (never a PLL output)
//   rst_n         asynchronous active-low reset
//   pll_lock      PLL lock indicator, asynchronous to clk
//   pll_restart   single-cycle pulse, forces a fresh sequence (top priority)
//   pll_rst       active-high PLL reset
//   sys_rst_n     active-low system reset, released only in RUN
//   locked_stable high while in RUN
//   timeout_err   high while in FAIL
//   retry_cnt     retries used in the current sequence
//   lock_lost_cnt saturating count of lock losses seen in RUN
module pll_lock_rst_ctrl #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       pll_restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       locked_stable,
    output logic       timeout_err,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    localparam int PW = $clog2(RST_PULSE_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PRST,
        S_WAIT,
        S_STAB,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pulse_cnt, pulse_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [SW-1:0] stab_cnt, stab_nxt;
    logic [3:0]    retry_nxt;
    logic [7:0]    lost_nxt;
    logic          lock_meta, lock_s;
    logic          stab_done, tmo_hit;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Lock qualification completing this cycle beats a coincident timeout.
    assign stab_done = (state == S_STAB) && lock_s && (stab_cnt == STAB_LAST);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        pulse_nxt = pulse_cnt;
        tmo_nxt   = tmo_cnt;
        stab_nxt  = stab_cnt;
        retry_nxt = retry_cnt;
        lost_nxt  = lock_lost_cnt;

        if (pll_restart) begin
            state_nxt = S_PRST;
            pulse_nxt = '0;
            tmo_nxt   = '0;
            stab_nxt  = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                S_PRST: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state_nxt = S_WAIT;
                        pulse_nxt = '0;
                        tmo_nxt   = '0;
                    end else begin
                        pulse_nxt = pulse_cnt + PW'(1);
                    end
                end
                S_WAIT, S_STAB: begin
                    if (stab_done) begin
                        state_nxt = S_RUN;
                        tmo_nxt   = '0;
                        stab_nxt  = '0;
                    end else if (tmo_hit) begin
                        tmo_nxt  = '0;
                        stab_nxt = '0;
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = S_FAIL;
                        end else begin
                            state_nxt = S_PRST;
                            pulse_nxt = '0;
                            retry_nxt = retry_cnt + 4'd1;
                        end
                    end else begin
                        // The attempt window keeps running across a lock
                        // glitch; only the stability count restarts.
                        tmo_nxt = tmo_cnt + TW'(1);
                        if (lock_s) begin
                            if (state == S_WAIT) begin
                                state_nxt = S_STAB;
                                stab_nxt  = '0;
                            end else begin
                                stab_nxt = stab_cnt + SW'(1);
                            end
                        end else begin
                            state_nxt = S_WAIT;
                            stab_nxt  = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nxt = S_PRST;
                        pulse_nxt = '0;
                        retry_nxt = '0;
                        if (lock_lost_cnt != 8'hFF) begin
                            lost_nxt = lock_lost_cnt + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_PRST;
                    pulse_nxt = '0;
                    tmo_nxt   = '0;
                    stab_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_PRST;
            pulse_cnt     <= '0;
            tmo_cnt       <= '0;
            stab_cnt      <= '0;
            retry_cnt     <= '0;
            lock_lost_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            locked_stable <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            pulse_cnt     <= pulse_nxt;
            tmo_cnt       <= tmo_nxt;
            stab_cnt      <= stab_nxt;
            retry_cnt     <= retry_nxt;
            lock_lost_cnt <= lost_nxt;
            pll_rst       <= (state_nxt == S_PRST);
            sys_rst_n     <= (state_nxt == S_RUN);
            locked_stable <= (state_nxt == S_RUN);
            timeout_err   <= (state_nxt == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// tb_pll_lock_rst_ctrl
//
// Bench for pll_lock_rst_ctrl with small parameters (pulse 4, stable 8,
// timeout 64, two retries). A table of {inputs, expected outputs} records
// covers nominal lock, lock loss and restart; hand-written sequences cover
// the lock glitch, saturation of the loss counter, restart against a
// timeout, the retry-to-FAIL path and an asynchronous reset in STAB; a
// random phase drives pll_lock and pll_restart against a reference model.
module tb_pll_lock_rst_ctrl;

    localparam int P = 4;
    localparam int S = 8;
    localparam int T = 64;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_restart = 1'b0;
    logic       pll_rst, sys_rst_n, locked_stable, timeout_err;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;
    logic [15:0] dut_out;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_rst_ctrl #(
        .RST_PULSE_CYCLES   (P),
        .LOCK_STABLE_CYCLES (S),
        .LOCK_TIMEOUT_CYCLES(T),
        .MAX_RETRY          (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .pll_restart  (pll_restart),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .locked_stable(locked_stable),
        .timeout_err  (timeout_err),
        .retry_cnt    (retry_cnt),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk = ~clk;

    assign dut_out = {pll_rst, sys_rst_n, locked_stable, timeout_err, retry_cnt, lock_lost_cnt};

    // Reference model: an attempt is a reset phase of P cycles followed by a
    // window of T cycles; the window succeeds once S+1 consecutive synced
    // lock samples have been seen in it, otherwise its last cycle is a
    // timeout. Synced lock is the input delayed by two sampling edges.
    typedef enum int {M_PRST, M_WIN, M_RUN, M_FAIL} mmode_t;
    mmode_t m_mode;
    int     m_t, m_streak, m_retry, m_lost;
    logic   m_h0, m_h1;

    function void model_reset();
        m_mode = M_PRST; m_t = 0; m_streak = 0; m_retry = 0; m_lost = 0;
        m_h0 = 1'b0; m_h1 = 1'b0;
    endfunction

    function void model_edge(input logic lk, input logic rs);
        logic ls;
        ls   = m_h1;
        m_h1 = m_h0;
        m_h0 = lk;
        if (rs) begin
            m_mode = M_PRST; m_t = 0; m_retry = 0;
        end else begin
            case (m_mode)
                M_PRST: begin
                    if (m_t == P - 1) begin m_mode = M_WIN; m_t = 0; m_streak = 0; end
                    else m_t++;
                end
                M_WIN: begin
                    m_streak = ls ? m_streak + 1 : 0;
                    if (m_streak == S + 1) m_mode = M_RUN;
                    else if (m_t == T - 1) begin
                        if (m_retry == R) m_mode = M_FAIL;
                        else begin m_retry++; m_mode = M_PRST; m_t = 0; end
                    end else m_t++;
                end
                M_RUN: begin
                    if (!ls) begin
                        m_mode = M_PRST; m_t = 0; m_retry = 0;
                        if (m_lost < 255) m_lost++;
                    end
                end
                default: m_mode = M_FAIL;
            endcase
        end
    endfunction

    function logic [15:0] model_out();
        return {m_mode == M_PRST, m_mode == M_RUN, m_mode == M_RUN, m_mode == M_FAIL,
                4'(m_retry), 8'(m_lost)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge(pll_lock, pll_restart);
        #1;
        check("model", {16'h0, dut_out}, {16'h0, model_out()});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        pll_restart = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       lock;
        logic       restart;
        int         n;
        logic       prst;
        logic       srn;
        logic       lst;
        logic       terr;
        logic [3:0] rc;
        logic [7:0] lost;
    } vec_t;

    vec_t tbl [11];

    logic       prst_h [0:1204];
    logic [3:0] rc_h   [0:1204];
    logic       te_h   [0:1204];
    logic       srn_h  [0:1204];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, found, found2, bad, bad2, hi, seg;
        logic exp_b;

        // Starts right after reset release (first step is edge 1).
        tbl[0]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // PRST edges 1-3
        tbl[1]  = '{1'b0, 1'b0, 17, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // WAIT edges 4-20
        tbl[2]  = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}; // sync + STAB
        tbl[3]  = '{1'b1, 1'b0,  5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0}; // RUN at rise+11
        tbl[4]  = '{1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0}; // drop still in sync
        tbl[5]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1}; // loss at 3rd edge
        tbl[6]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1};
        tbl[7]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1}; // WAIT
        tbl[8]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1}; // restart
        tbl[9]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1};
        tbl[10] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1};

        // Reset state
        do_reset();
        check("reset_state", {16'h0, dut_out}, 32'h8000);

        // Table: nominal lock, loss in RUN, restart
        for (int i = 0; i < 11; i++) begin
            pll_lock = tbl[i].lock;
            pll_restart = tbl[i].restart;
            for (int j = 0; j < tbl[i].n; j++) begin
                step();
                check($sformatf("tbl%0d.%0d", i, j), {16'h0, dut_out},
                      {16'h0, tbl[i].prst, tbl[i].srn, tbl[i].lst, tbl[i].terr, tbl[i].rc, tbl[i].lost});
            end
        end
        pll_restart = 1'b0;

        // Glitch during STAB
        do_reset();
        repeat (6) step();
        bad = 0;
        pll_lock = 1'b1;
        repeat (5) begin step(); if (sys_rst_n !== 1'b0 || pll_rst !== 1'b0) bad++; end
        pll_lock = 1'b0;
        repeat (3) begin step(); if (sys_rst_n !== 1'b0 || pll_rst !== 1'b0) bad++; end
        pll_lock = 1'b1;
        k = 0; found = 0;
        while (k < 30 && found == 0) begin
            step(); k++;
            if (sys_rst_n === 1'b1) found = 1;
            else if (pll_rst !== 1'b0) bad++;
        end
        check("glitch_quiet", bad, 0);
        check("glitch_rise_found", found, 1);
        check("glitch_rise_edges_10to12", (k >= 10 && k <= 12) ? 1 : 0, 1);
        check("glitch_lost_cnt", lock_lost_cnt, 0);
        check("glitch_retry_cnt", retry_cnt, 0);

        // Repeated lock loss in RUN, counter saturation
        for (int i = 0; i < 260; i++) begin
            pll_lock = 1'b0;
            k = 0; found = 0;
            while (k < 6 && found == 0) begin
                step(); k++;
                if (sys_rst_n === 1'b0) found = 1;
            end
            check("loss_fall_edges", k, 3);
            check("loss_pll_rst", pll_rst, 1);
            check("loss_cnt", lock_lost_cnt, (i + 1 > 255) ? 255 : i + 1);
            pll_lock = 1'b1;
            k = 0; found = 0;
            while (k < 40 && found == 0) begin
                step(); k++;
                if (locked_stable === 1'b1) found = 1;
            end
            check("relock", found, 1);
        end

        // Restart coinciding with a timeout (entered from RUN)
        pll_lock = 1'b0;
        k = 0; found = 0;
        while (k < 10 && found == 0) begin step(); k++; if (pll_rst === 1'b1) found = 1; end
        k = 0; found2 = 0;
        while (k < 10 && found2 == 0) begin step(); k++; if (pll_rst === 1'b0) found2 = 1; end
        check("prio_prst_seen", found, 1);
        check("prio_wait_seen", found2, 1);
        repeat (T - 1) step();
        pll_restart = 1'b1;
        step();
        pll_restart = 1'b0;
        check("prio_pll_rst", pll_rst, 1);
        check("prio_retry_cnt", retry_cnt, 0);
        check("prio_timeout_err", timeout_err, 0);
        check("prio_lost_kept", lock_lost_cnt, 255);
        hi = 1; k = 0; found = 0;
        while (k < 10 && found == 0) begin
            step(); k++;
            if (pll_rst === 1'b1) hi++; else found = 1;
        end
        check("prio_pulse_len", hi, P);

        // Timeout and retry to FAIL, lock tied low
        do_reset();
        for (int e = 1; e <= 1204; e++) begin
            step();
            prst_h[e] = pll_rst; rc_h[e] = retry_cnt; te_h[e] = timeout_err; srn_h[e] = sys_rst_n;
        end
        bad = 0; bad2 = 0;
        for (int e = 1; e <= 1204; e++) begin
            exp_b = (e < 4) || (e >= 68 && e < 72) || (e >= 136 && e < 140);
            if (prst_h[e] !== exp_b) bad++;
            if (e >= 204 && (te_h[e] !== 1'b1 || srn_h[e] !== 1'b0 || rc_h[e] !== 4'd2)) bad2++;
        end
        check("fail_pulse_pattern", bad, 0);
        check("fail_rc_67", rc_h[67], 0);
        check("fail_rc_68", rc_h[68], 1);
        check("fail_rc_135", rc_h[135], 1);
        check("fail_rc_136", rc_h[136], 2);
        check("fail_te_203", te_h[203], 0);
        check("fail_te_204", te_h[204], 1);
        check("fail_hold", bad2, 0);

        // Restart out of FAIL
        pll_restart = 1'b1;
        step();
        pll_restart = 1'b0;
        check("restart_fail_pll_rst", pll_rst, 1);
        check("restart_fail_timeout_err", timeout_err, 0);
        check("restart_fail_retry", retry_cnt, 0);

        // One timeout, then asynchronous reset while in STAB
        k = 0; found = 0;
        while (k < 100 && found == 0) begin step(); k++; if (retry_cnt === 4'd1) found = 1; end
        check("retry_after_timeout", found, 1);
        repeat (P) step();
        check("wait_after_retry", pll_rst, 0);
        pll_lock = 1'b1;
        repeat (8) step();
        check("pre_reset_retry", retry_cnt, 1);
        check("pre_reset_srn", sys_rst_n, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", {16'h0, dut_out}, 32'h8000);
        pll_lock = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // Randomized lock behaviour and restarts against the model
        seg = 0;
        for (int c = 0; c < 8000; c++) begin
            if (seg == 0) begin
                pll_lock = ~pll_lock;
                seg = pll_lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 90));
            end
            seg--;
            pll_restart = ($urandom_range(0, 299) == 0);
            step();
        end
        pll_restart = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
